reg_read_port: RTL

REG_READ_PORT -- requirements
Module: reg_read_port

---
 rtl/reg_read_port.sv | 64 ++++++
 1 files changed

// File: rtl/reg_read_port.sv
// reg_read_port: registered two-port read of a 32-entry register file with valid/ready handshake.
// Optional REG_READ_BYPASS_EN: write-first bypass on accept plus refresh of held results.
module reg_read_port #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [4:0]                        Rn,
  input  logic [4:0]                        Rm,
  input  logic [31:0][DATA_WIDTH-1:0]       read_list,
  input  logic                              wb_en,
  input  logic [4:0]                        wb_reg,
  input  logic [DATA_WIDTH-1:0]             wb_data,
  input  logic                              flush,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATA_WIDTH-1:0]             Da,
  output logic [DATA_WIDTH-1:0]             Db,
  output logic [4:0]                        out_Rn,
  output logic [4:0]                        out_Rm
);
  logic                  acc;
  logic [DATA_WIDTH-1:0] ra, rb, ha, hb;
  assign in_ready = (!out_valid || out_ready) && !flush;
  assign acc = in_valid && in_ready;
`ifdef REG_READ_BYPASS_EN
  assign ra = (Rn == 5'd31) ? '0 : (wb_en && wb_reg == Rn) ? wb_data : read_list[Rn];
  assign rb = (Rm == 5'd31) ? '0 : (wb_en && wb_reg == Rm) ? wb_data : read_list[Rm];
  // a held result must not go stale when its source register is rewritten
  assign ha = (wb_en && wb_reg == out_Rn && out_Rn != 5'd31) ? wb_data : Da;
  assign hb = (wb_en && wb_reg == out_Rm && out_Rm != 5'd31) ? wb_data : Db;
`else
  logic unused_wb;
  assign unused_wb = ^{wb_en, wb_reg, wb_data};
  assign ra = (Rn == 5'd31) ? '0 : read_list[Rn];
  assign rb = (Rm == 5'd31) ? '0 : read_list[Rm];
  assign ha = Da;
  assign hb = Db;
`endif
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      Da        <= '0;
      Db        <= '0;
      out_Rn    <= '0;
      out_Rm    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (acc) begin
      out_valid <= 1'b1;
      Da        <= ra;
      Db        <= rb;
      out_Rn    <= Rn;
      out_Rm    <= Rm;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end else if (out_valid) begin
      Da <= ha;
      Db <= hb;
    end
  end
endmodule
